apb_cmd_master: RTL and testbench
=================================

APB_CMD_MASTER -- requirements
Module: apb_cmd_master

Interface
REQ-001 Parameters SHALL be: ADDR_WIDTH, default 7, APB address width; DATA_WIDTH, default 32, APB data width; COMP, default 4, number of completers (PSELx width); TIMEOUT, default 16, maximum ACCESS cycles before error.
REQ-002 Ports SHALL be, in this order:
- clk  in  1  single clock; all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  host command present.
- cmd_ready  out  1  command accepted this cycle when high with cmd_valid.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_sel  in  $clog2(COMP)  completer index.
- cmd_addr  in  ADDR_WIDTH  target address.
- cmd_wdata  in  DATA_WIDTH  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  host accepts response.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and errors.
- rsp_err  out  1  transfer timed out.
- busy  out  1  high whenever state is not IDLE.
- PSELx  out  COMP  one-hot completer select.
- PENABLE  out  1  APB access phase.
- PWRITE  out  1  APB direction.
- PADDR  out  ADDR_WIDTH  APB address.
- PWDATA  out  DATA_WIDTH  APB write data.
- PREADY  in  1  completer ready.
- PRDATA  in  DATA_WIDTH  completer read data.

Function
REQ-003 FSM states SHALL be IDLE, SETUP, ACCESS and RESP, with registered outputs.
REQ-004 cmd_ready SHALL be high only in IDLE; a handshake SHALL latch write, sel, addr and wdata and move to SETUP on the next edge.
REQ-005 SETUP SHALL last exactly one cycle with PSELx = 1<<sel, PENABLE=0 and PADDR/PWRITE/PWDATA driven from the latched command; next state is ACCESS.
REQ-006 ACCESS SHALL hold PSELx, PADDR, PWRITE and PWDATA unchanged from SETUP, with PENABLE=1.
REQ-007 In ACCESS with PREADY=1, the block SHALL:
- capture PRDATA into rsp_rdata for reads, or 0 for writes;
- set rsp_err=0;
- go to RESP.
REQ-008 In ACCESS with PREADY=0, a wait counter SHALL increment; when it reaches TIMEOUT-1 without PREADY, the block SHALL set rsp_err=1 and rsp_rdata=0 and go to RESP.
REQ-009 PREADY=1 in the same cycle as the counter reaching TIMEOUT-1 SHALL count as success.
REQ-010 On leaving ACCESS, PSELx and PENABLE SHALL be 0 in the next cycle; PADDR, PWRITE and PWDATA MAY hold their last value.
REQ-011 In RESP, rsp_valid SHALL be 1 and rsp_rdata/rsp_err SHALL be stable until rsp_ready=1; the block then returns to IDLE on the next edge.
REQ-012 Zero-wait-state latency SHALL be: accept at edge 0, SETUP in cycle 1, ACCESS in cycle 2, rsp_valid in cycle 3.
REQ-013 Back-to-back operation SHALL be possible: the earliest next command is accepted in the cycle after the response handshake, with no new command accepted while busy.
REQ-014 The wait counter SHALL clear on every entry to ACCESS and SHALL never wrap.
REQ-015 cmd_sel values at or above COMP SHALL produce an immediate RESP with rsp_err=1 and no bus activity (PSELx stays 0).

Reset
REQ-016 Synchronous rst SHALL force IDLE with these values on the next edge: cmd_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=0, busy=0, PSELx=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, counter=0.
REQ-017 Reset in SETUP, ACCESS or RESP SHALL abort the transfer with no response emitted; any pending response SHALL be discarded.
REQ-018 rst SHALL take priority over every other input.

Structure
REQ-019 A shared package apb_pkg SHALL hold:
- the FSM state enum (IDLE, SETUP, ACCESS, RESP);
- default ADDR_WIDTH, DATA_WIDTH, COMP and TIMEOUT;
- a command struct (write, sel, addr, wdata).
REQ-020 The block SHALL be a single module with no sub-modules, sized at 120-400 RTL lines.

Verification
REQ-021 Write, sel=2, addr=0x05, wdata=0x000ABCDE, PREADY tied 1 -> PSELx=4'b0100 in cycles 1-2, PENABLE=1 in cycle 2 only, rsp_valid in cycle 3 with rsp_err=0 and rsp_rdata=0.
REQ-022 Read, sel=0, addr=0x10, completer holds PREADY=0 for 3 ACCESS cycles then PRDATA=0x1234 with PREADY=1 -> PADDR stable throughout, rsp_rdata=0x1234, rsp_err=0.
REQ-023 Read with PREADY stuck 0 and TIMEOUT=16 -> exactly 16 ACCESS cycles, then rsp_err=1, rsp_rdata=0, PSELx=0.
REQ-024 rsp_ready held 0 for 5 cycles -> rsp_valid and data held stable, cmd_ready=0, second cmd_valid not accepted until after the response handshake.
REQ-025 rst asserted during ACCESS -> next cycle PSELx=0, PENABLE=0, IDLE state, no rsp_valid pulse.
REQ-026 Two consecutive commands with rsp_ready tied 1 -> second SETUP begins 2 cycles after the first rsp_valid.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared types and default sizing for the APB command master.
package apb_pkg;

  localparam int DEF_ADDR_WIDTH = 7;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_COMP       = 4;
  localparam int DEF_TIMEOUT    = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

  // Host command as seen at the default sizing.
  typedef struct packed {
    logic                          write;
    logic [$clog2(DEF_COMP)-1:0]   sel;
    logic [DEF_ADDR_WIDTH-1:0]     addr;
    logic [DEF_DATA_WIDTH-1:0]     wdata;
  } apb_cmd_t;

endpackage

// File: rtl/apb_cmd_master.sv
// Host-command to APB requester bridge with wait-state timeout.
//
// state  | meaning
// IDLE   | ready for a host command
// SETUP  | APB setup phase, PSELx asserted, PENABLE low
// ACCESS | APB access phase, waiting for PREADY or timeout
// RESP   | response held on rsp_* until the host takes it
module apb_cmd_master
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int COMP       = DEF_COMP,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_write,
  input  logic [$clog2(COMP)-1:0]  cmd_sel,
  input  logic [ADDR_WIDTH-1:0]    cmd_addr,
  input  logic [DATA_WIDTH-1:0]    cmd_wdata,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATA_WIDTH-1:0]    rsp_rdata,
  output logic                     rsp_err,
  output logic                     busy,
  output logic [COMP-1:0]          PSELx,
  output logic                     PENABLE,
  output logic                     PWRITE,
  output logic [ADDR_WIDTH-1:0]    PADDR,
  output logic [DATA_WIDTH-1:0]    PWDATA,
  input  logic                     PREADY,
  input  logic [DATA_WIDTH-1:0]    PRDATA
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [COMP-1:0]  SEL_ONE  = COMP'(1);

  apb_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  busy_q, busy_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [COMP-1:0]       pselx_q, pselx_d;
  logic                  penable_q, penable_d;
  logic                  pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;

  // Widened so the range check stays meaningful when COMP is a power of two.
  logic [31:0] sel_ext;
  assign sel_ext = 32'(cmd_sel);

  // Next-state and next-output decode for the transfer FSM.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cmd_ready_d = cmd_ready_q;
    busy_d      = busy_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    pselx_d     = pselx_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          cmd_ready_d = 1'b0;
          busy_d      = 1'b1;
          if (sel_ext >= 32'(COMP)) begin
            // Nonexistent completer: report an error without touching the bus.
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end else begin
            state_d  = SETUP;
            pselx_d  = SEL_ONE << cmd_sel;
            pwrite_d = cmd_write;
            paddr_d  = cmd_addr;
            pwdata_d = cmd_wdata;
          end
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
        cnt_d     = '0;
      end
      ACCESS: begin
        if (PREADY || (cnt_q == CNT_LAST)) begin
          // PREADY wins when it coincides with the last allowed wait cycle.
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = ~PREADY;
          rsp_rdata_d = (PREADY && !pwrite_q) ? PRDATA : '0;
          pselx_d     = '0;
          penable_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          busy_d      = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      pselx_q     <= '0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      pselx_q     <= pselx_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign busy      = busy_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign PSELx     = pselx_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed bench for apb_cmd_master at default sizing.
module tb_apb_cmd_master;
  import apb_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [1:0]  cmd_sel = '0;
  logic [6:0]  cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;
  logic [3:0]  PSELx;
  logic        PENABLE;
  logic        PWRITE;
  logic [6:0]  PADDR;
  logic [31:0] PWDATA;
  logic        PREADY = 1'b0;
  logic [31:0] PRDATA = '0;

  int total = 0;
  int fails = 0;

  apb_cmd_master dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_sel(cmd_sel), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .busy(busy),
    .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PREADY(PREADY), .PRDATA(PRDATA)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_cmd(input apb_cmd_t c);
    cmd_valid = 1'b1;
    cmd_write = c.write;
    cmd_sel   = c.sel;
    cmd_addr  = c.addr;
    cmd_wdata = c.wdata;
  endtask

  initial begin
    apb_cmd_t c;
    int n;

    // Reset state
    tick(); tick();
    rst = 1'b0;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_err",   32'(rsp_err),   32'd0);
    chk("rst_rsp_rdata", rsp_rdata,      32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_pselx",     32'(PSELx),     32'd0);
    chk("rst_penable",   32'(PENABLE),   32'd0);
    chk("rst_pwrite",    32'(PWRITE),    32'd0);
    chk("rst_paddr",     32'(PADDR),     32'd0);
    chk("rst_pwdata",    PWDATA,         32'd0);

    // Zero-wait write, sel=2
    PREADY = 1'b1;
    c = '{write: 1'b1, sel: 2'd2, addr: 7'h05, wdata: 32'h000ABCDE};
    drive_cmd(c);
    tick();
    cmd_valid = 1'b0;
    chk("wr_c1_pselx",   32'(PSELx),   32'h4);
    chk("wr_c1_penable", 32'(PENABLE), 32'd0);
    chk("wr_c1_busy",    32'(busy),    32'd1);
    chk("wr_c1_pwdata",  PWDATA,       32'h000ABCDE);
    chk("wr_c1_pwrite",  32'(PWRITE),  32'd1);
    tick();
    chk("wr_c2_pselx",   32'(PSELx),   32'h4);
    chk("wr_c2_penable", 32'(PENABLE), 32'd1);
    chk("wr_c2_paddr",   32'(PADDR),   32'h05);
    tick();
    chk("wr_c3_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("wr_c3_rsp_err",   32'(rsp_err),   32'd0);
    chk("wr_c3_rsp_rdata", rsp_rdata,      32'd0);
    chk("wr_c3_pselx",     32'(PSELx),     32'd0);
    chk("wr_c3_penable",   32'(PENABLE),   32'd0);
    rsp_ready = 1'b1;
    tick();
    chk("wr_c4_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("wr_c4_rsp_valid", 32'(rsp_valid), 32'd0);

    // Read with 3 wait states, then response held for 5 cycles
    rsp_ready = 1'b0;
    PREADY = 1'b0;
    c = '{write: 1'b0, sel: 2'd0, addr: 7'h10, wdata: 32'h0};
    drive_cmd(c);
    tick();
    cmd_valid = 1'b0;
    chk("rd_setup_pselx", 32'(PSELx), 32'h1);
    chk("rd_setup_paddr", 32'(PADDR), 32'h10);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("rd_wait_penable", 32'(PENABLE), 32'd1);
      chk("rd_wait_paddr",   32'(PADDR),   32'h10);
      chk("rd_wait_pselx",   32'(PSELx),   32'h1);
      tick();
    end
    chk("rd_last_penable", 32'(PENABLE), 32'd1);
    chk("rd_last_paddr",   32'(PADDR),   32'h10);
    PREADY = 1'b1;
    PRDATA = 32'h1234;
    tick();
    PREADY = 1'b0;
    PRDATA = 32'hFFFF_FFFF;
    c = '{write: 1'b1, sel: 2'd1, addr: 7'h22, wdata: 32'h55};
    drive_cmd(c);
    for (int i = 0; i < 5; i++) begin
      chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("hold_rsp_rdata", rsp_rdata,      32'h1234);
      chk("hold_rsp_err",   32'(rsp_err),   32'd0);
      chk("hold_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("hold_pselx",     32'(PSELx),     32'd0);
      tick();
    end
    chk("hold_end_rsp_valid", 32'(rsp_valid), 32'd1);
    rsp_ready = 1'b1;
    tick();
    chk("hs_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("hs_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("hs_pselx",     32'(PSELx),     32'd0);
    tick();
    cmd_valid = 1'b0;
    chk("second_pselx",  32'(PSELx),  32'h2);
    chk("second_paddr",  32'(PADDR),  32'h22);
    chk("second_pwrite", 32'(PWRITE), 32'd1);
    PREADY = 1'b1;
    tick();
    tick();
    chk("second_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("second_rsp_rdata", rsp_rdata,      32'd0);
    tick();
    chk("second_idle", 32'(cmd_ready), 32'd1);

    // Timeout: PREADY stuck low
    PREADY = 1'b0;
    PRDATA = 32'hDEAD;
    rsp_ready = 1'b0;
    c = '{write: 1'b0, sel: 2'd3, addr: 7'h7F, wdata: 32'h0};
    drive_cmd(c);
    tick();
    cmd_valid = 1'b0;
    chk("to_setup_pselx", 32'(PSELx), 32'h8);
    tick();
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (PENABLE !== 1'b1) break;
      n++;
      tick();
    end
    chk("to_access_cycles", 32'(n),         32'd16);
    chk("to_rsp_valid",     32'(rsp_valid), 32'd1);
    chk("to_rsp_err",       32'(rsp_err),   32'd1);
    chk("to_rsp_rdata",     rsp_rdata,      32'd0);
    chk("to_pselx",         32'(PSELx),     32'd0);
    rsp_ready = 1'b1;
    tick();
    chk("to_idle", 32'(cmd_ready), 32'd1);

    // PREADY on the last allowed wait cycle is a success
    c = '{write: 1'b0, sel: 2'd1, addr: 7'h01, wdata: 32'h0};
    drive_cmd(c);
    tick();
    cmd_valid = 1'b0;
    tick();
    for (int i = 0; i < 15; i++) tick();
    chk("edge_penable", 32'(PENABLE), 32'd1);
    PREADY = 1'b1;
    PRDATA = 32'hCAFE;
    tick();
    PREADY = 1'b0;
    chk("edge_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("edge_rsp_err",   32'(rsp_err),   32'd0);
    chk("edge_rsp_rdata", rsp_rdata,      32'hCAFE);
    tick();

    // Reset during ACCESS
    c = '{write: 1'b1, sel: 2'd2, addr: 7'h0A, wdata: 32'h77};
    drive_cmd(c);
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("ra_in_access", 32'(PENABLE), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("ra_pselx",     32'(PSELx),     32'd0);
    chk("ra_penable",   32'(PENABLE),   32'd0);
    chk("ra_busy",      32'(busy),      32'd0);
    chk("ra_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("ra_rsp_valid", 32'(rsp_valid), 32'd0);
    tick();
    chk("ra_rsp_valid_after", 32'(rsp_valid), 32'd0);

    // Back-to-back with rsp_ready tied high
    PREADY = 1'b1;
    rsp_ready = 1'b1;
    c = '{write: 1'b0, sel: 2'd0, addr: 7'h31, wdata: 32'h0};
    drive_cmd(c);
    tick();
    c = '{write: 1'b0, sel: 2'd1, addr: 7'h33, wdata: 32'h0};
    drive_cmd(c);
    chk("b2b_c1_paddr", 32'(PADDR), 32'h31);
    tick();
    tick();
    chk("b2b_c3_rsp_valid", 32'(rsp_valid), 32'd1);
    tick();
    chk("b2b_c4_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("b2b_c4_pselx",     32'(PSELx),     32'd0);
    tick();
    cmd_valid = 1'b0;
    chk("b2b_c5_pselx",   32'(PSELx),   32'h2);
    chk("b2b_c5_penable", 32'(PENABLE), 32'd0);
    chk("b2b_c5_paddr",   32'(PADDR),   32'h33);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
